serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder: computes A + B + carry_in over WIDTH clock cycles, LSB first, using a single full-adder cell and a registered carry.
- Sequential counterpart to the team's ripple-carry subtract datapath; trades latency for area in low-rate arithmetic paths.
- Start/done handshake. Result and carry are held stable on registered outputs until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when idle.
- A  input  WIDTH  operand A; sampled on an accepted start.
- B  input  WIDTH  operand B; sampled on an accepted start.
- carry_in  input  1  carry into bit 0; sampled on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid and updated this cycle.
- sum  output  WIDTH  registered result (A + B + carry_in) mod 2^WIDTH.
- carry_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - No asynchronous logic.
- Reset:
  - State returns to IDLE.
  - busy, done, sum and carry_out are all 0.
  - Internal shift registers, carry flop and bit counter are 0.
- States:
  - IDLE:
    - busy=0.
    - If start=1 at a rising edge: load A and B into shift registers, load carry_in into the carry flop, clear the bit counter, go to RUN.
    - If start=0, stay in IDLE.
  - RUN:
    - busy=1.
    - Each edge processes one bit using the LSBs of the A/B shift registers and the carry flop:
      - s = a ^ b ^ c
      - c' = (a & b) | ((a ^ b) & c)
    - Shift the A and B registers right by one.
    - Shift s into the MSB of the partial-sum register (right shift).
    - Increment the counter.
    - On the edge where the counter equals WIDTH-1 (the final bit):
      - Copy the completed partial sum (including this edge's s) into the sum output register.
      - Copy c' into carry_out.
      - Set done=1 and return to IDLE.
- Latency: start accepted at edge k, so done=1 and the new sum/carry_out are visible after edge k+WIDTH, for exactly one cycle.
- done:
  - Registered.
  - High for exactly one cycle per completed operation.
  - Never asserted without a preceding accepted start.
- Held outputs:
  - sum and carry_out change only at a done edge or at reset.
  - Between operations they hold the last result.
- start while busy: ignored. No queuing, no effect on the operation in flight.
- Back-to-back:
  - The done cycle has state=IDLE, so start=1 in that cycle is accepted at the next edge.
  - Sustained throughput: one result per WIDTH+1 cycles.
- Operand stability: A, B and carry_in are don't-care except at the accepting edge.
- Overflow: modular. Carry from the top bit is reported only on carry_out.
- Reset mid-operation:
  - Aborts the operation immediately.
  - No done pulse.
  - sum and carry_out are cleared to 0.
  - The next start begins a clean operation.
- Reset with start: if rst=1 and start=1 at the same edge, rst wins and the start is dropped.
- Counter width: $clog2(WIDTH) bits, with no wrap inside one operation.

Test Plan:
- WIDTH=8, A=0x35, B=0x4A, carry_in=0, start pulse at edge k -> busy=1 for edges k..k+7; done=1 after edge k+8; sum=0x7F, carry_out=0.
- A=0xFF, B=0x01, carry_in=0 -> sum=0x00, carry_out=1. Then A=0xFF, B=0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
- Start accepted with A=0x10, B=0x20; start re-asserted with A=0xAA, B=0x55 during RUN -> ignored; single done with sum=0x30, carry_out=0; sum holds 0x30 afterwards.
- Back-to-back: start held high continuously with A=0x01, B=0x02, then A=0x80, B=0x80 -> done pulses 9 cycles apart; results 0x03/cout 0, then 0x00/cout 1.
- rst asserted 4 cycles into an operation (A=0x0F, B=0x0F) -> no done; busy, sum and carry_out=0 on the next cycle; following op 0x0F+0x0F -> 0x1E.
- WIDTH=16, A=0xFFFF, B=0x0001, carry_in=1 -> done 16 cycles after the accepting edge; sum=0x0001, carry_out=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial A + B + carry_in, LSB first, one full-adder cell, start/done handshake
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_psum, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c, r_cout, r_done;
    logic             w_s, w_c, w_last;
    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c    = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_c);
    assign w_last = r_cnt == CW'(WIDTH - 1);
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) : (w_last ? IDLE : RUN);
    end
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_psum <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_a   <= A;
                r_b   <= B;
                r_c   <= carry_in;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_a    <= r_a >> 1;
                r_b    <= r_b >> 1;
                r_c    <= w_c;
                r_psum <= {w_s, r_psum[WIDTH-1:1]};
                r_cnt  <= r_cnt + CW'(1);
                // final bit: this edge's sum bit completes the result
                if (w_last) begin
                    r_sum  <= {w_s, r_psum[WIDTH-1:1]};
                    r_cout <= w_c;
                    r_done <= 1'b1;
                end
            end
        end
    end
    assign busy      = r_state == RUN;
    assign done      = r_done;
    assign sum       = r_sum;
    assign carry_out = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors with a scoreboard queue per DUT and decoupled done monitors
module tb_serial_adder;
    typedef struct {
        logic [15:0] s;
        logic        c;
        int          due;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst, start, carry_in, busy, done, carry_out;
    logic [7:0]  A, B, sum;
    logic        s_start, s_carry_in, s_busy, s_done, s_carry_out;
    logic [15:0] s_A, s_B, s_sum;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        q8[$];
    exp_t        q16[$];
    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .carry_in(carry_in),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
    );
    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s_start), .A(s_A), .B(s_B), .carry_in(s_carry_in),
        .busy(s_busy), .done(s_done), .sum(s_sum), .carry_out(s_carry_out)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q8.size() == 0) begin
                n_total++;
                $display("FAIL done8_unexpected: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = q8.pop_front();
                chk("sum8", {24'h0, sum}, {16'h0, e.s});
                chk("cout8", {31'h0, carry_out}, {31'h0, e.c});
                chk("latency8", cyc, e.due);
                chk("busy8_at_done", {31'h0, busy}, 32'h0);
            end
        end
        if (s_done) begin
            if (q16.size() == 0) begin
                n_total++;
                $display("FAIL done16_unexpected: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = q16.pop_front();
                chk("sum16", {16'h0, s_sum}, {16'h0, e.s});
                chk("cout16", {31'h0, s_carry_out}, {31'h0, e.c});
                chk("latency16", cyc, e.due);
            end
        end
    end
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec);
        start = 1'b1; A = a; B = b; carry_in = ci;
        @(posedge clk); #1;
        q8.push_back('{{8'h0, es}, ec, cyc + 8});
        chk("busy8_run", {31'h0, busy}, 32'h1);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; carry_in = 1'b0;
        s_start = 1'b0; s_A = '0; s_B = '0; s_carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_sum", {24'h0, sum}, 32'h0);
        chk("rst_cout", {31'h0, carry_out}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        // start held through RUN with other operands must not disturb the op
        start = 1'b1; A = 8'h10; B = 8'h20; carry_in = 1'b0;
        @(posedge clk); #1;
        q8.push_back('{16'h0030, 1'b0, cyc + 8});
        A = 8'hAA; B = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        chk("busy8_ignored_start", {31'h0, busy}, 32'h1);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sum", {24'h0, sum}, 32'h30);
        chk("hold_cout", {31'h0, carry_out}, 32'h0);
        chk("hold_busy", {31'h0, busy}, 32'h0);
        // back-to-back with start held high: second op accepted at the done edge+1
        start = 1'b1; A = 8'h01; B = 8'h02;
        @(posedge clk); #1;
        q8.push_back('{16'h0003, 1'b0, cyc + 8});
        A = 8'h80; B = 8'h80;
        repeat (8) @(posedge clk);
        #1;
        @(posedge clk); #1;
        q8.push_back('{16'h0000, 1'b1, cyc + 8});
        chk("busy8_b2b", {31'h0, busy}, 32'h1);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        op8(8'h12, 8'h1E, 1'b0, 8'h30, 1'b0);
        // abort mid-operation; rst also wins over a simultaneous start
        start = 1'b1; A = 8'h0F; B = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy8_pre_abort", {31'h0, busy}, 32'h1);
        rst = 1'b1; start = 1'b1; A = 8'h33; B = 8'h44;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_sum", {24'h0, sum}, 32'h0);
        chk("abort_cout", {31'h0, carry_out}, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_idle", {31'h0, busy}, 32'h0);
        op8(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0);
        s_start = 1'b1; s_A = 16'hFFFF; s_B = 16'h0001; s_carry_in = 1'b1;
        @(posedge clk); #1;
        q16.push_back('{16'h0001, 1'b1, cyc + 16});
        chk("busy16_run", {31'h0, s_busy}, 32'h1);
        s_start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        chk("q8_drained", q8.size(), 32'h0);
        chk("q16_drained", q16.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
